door_lock_ctrl: RTL
===================

Name: door_lock_ctrl

Overview:
Smart-house door lock controller that sits directly downstream of the serial code-sequence detector. It consumes the detector's one-cycle "code matched" pulse and a "bad entry" pulse, and drives the door strike for a timed unlock window. It counts failed attempts and enters a timed lockout after too many, and raises an alarm if the door is forced open while locked.

Parameters:
UNLOCK_CYCLES, 16, cycles unlock is held after a valid code (1..2^CNT_W)
LOCKOUT_CYCLES, 32, cycles codes are ignored after MAX_FAILS bad entries (1..2^CNT_W)
MAX_FAILS, 3, consecutive bad entries that trigger lockout (1..15)
CNT_W, 8, width of the shared down-timer

Ports:
clock  input  1  system clock, all state changes on posedge
reset  input  1  synchronous, active-low; sampled on posedge clock
code_ok  input  1  one-cycle pulse from the sequence detector: full code matched
code_bad  input  1  one-cycle pulse: a code entry completed without a match
door_closed  input  1  door sensor level, 1 = closed
lock_req  input  1  manual relock request (level or pulse)
unlock  output  1  door strike drive, 1 = unlocked
alarm  output  1  forced-entry alarm
locked_out  output  1  lockout active, codes ignored
fail_cnt  output  4  current consecutive bad-entry count

Behaviour:
- All outputs are registered and decoded from state: unlock=1 in UNLOCKED and HOLD; alarm=1 in ALARM; locked_out=1 in LOCKOUT. fail_cnt is a register.
- Latency: an input sampled at posedge N is reflected on the outputs after posedge N (one-cycle latency).
- Reset (reset==0 at posedge): state LOCKED, timer=0, fail_cnt=0, unlock=0, alarm=0, locked_out=0. Reset overrides every other input, including mid-unlock and mid-lockout.
- States: LOCKED, UNLOCKED, HOLD, LOCKOUT, ALARM.
- LOCKED: priority is door_closed==0 > code_ok > code_bad.
  - door_closed==0 -> ALARM; fail_cnt unchanged.
  - code_ok -> UNLOCKED; timer=UNLOCK_CYCLES-1; fail_cnt=0. If code_bad arrives in the same cycle, it is discarded.
  - code_bad -> fail_cnt+1. If fail_cnt+1==MAX_FAILS: go to LOCKOUT, timer=LOCKOUT_CYCLES-1, fail_cnt=0.
- UNLOCKED:
  - code_ok reloads timer=UNLOCK_CYCLES-1.
  - Otherwise, if lock_req==1 or timer==0, leave: go to LOCKED if door_closed==1, else HOLD.
  - Otherwise timer decrements.
  - code_bad is ignored.
  - With no events, unlock is high for exactly UNLOCK_CYCLES cycles.
- HOLD: door still open after relock. unlock stays 1; go to LOCKED on the first cycle door_closed==1. code_ok/code_bad ignored.
- LOCKOUT:
  - code_ok and code_bad are ignored, with fail_cnt held at 0.
  - door_closed==0 -> ALARM (has priority).
  - Otherwise timer==0 -> LOCKED, else timer decrements.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles if undisturbed.
- ALARM:
  - alarm stays 1 until code_ok, independent of door_closed.
  - code_ok -> UNLOCKED; timer=UNLOCK_CYCLES-1; fail_cnt=0.
  - code_bad ignored.
- Timer arithmetic: unsigned CNT_W bits, never decremented below 0 (no wrap).
- fail_cnt saturates at MAX_FAILS-1 by construction.
- MAX_FAILS=1: a single code_bad goes straight to LOCKOUT with fail_cnt=0.
- Unreachable or illegal state encoding -> LOCKED on the next clock, with outputs cleared.

Test Plan:
- Reset low 2 cycles, then high, door_closed=1, no pulses -> unlock=0, alarm=0, locked_out=0, fail_cnt=0 held for 50 cycles.
- code_ok pulse at cycle 10, door_closed=1 -> unlock=1 in cycles 11..26 (16 cycles), 0 at cycle 27; a second code_ok at cycle 20 extends unlock through cycle 36.
- Three code_bad pulses at cycles 5, 8, 11 -> fail_cnt 1, 2, then 0 with locked_out=1 in cycles 12..43. A code_ok at cycle 20 is ignored (unlock stays 0). locked_out=0 at cycle 44.
- Two code_bad then code_ok -> fail_cnt goes 1, 2, 0 and unlock asserts; a code_ok and code_bad in the same LOCKED cycle -> UNLOCKED, fail_cnt=0.
- Unlock window expires with door_closed=0 -> unlock stays 1 (HOLD); door_closed rises at cycle N -> unlock=0 at N+1. lock_req=1 mid-window with the door closed -> unlock=0 next cycle.
- door_closed=0 while LOCKED (and separately during LOCKOUT) -> alarm=1 next cycle, held after the door closes. code_ok -> alarm=0, unlock=1. reset=0 during ALARM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/door_lock_ctrl.sv
// Door lock controller: turns code-detector pulses into a timed door strike
// window, tracks consecutive bad entries with a timed lockout, and raises a
// latched alarm when the door opens while it should be locked.
module door_lock_ctrl #(
    parameter int unsigned UNLOCK_CYCLES  = 16,
    parameter int unsigned LOCKOUT_CYCLES = 32,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       code_ok,
    input  logic       code_bad,
    input  logic       door_closed,
    input  logic       lock_req,
    output logic       unlock,
    output logic       alarm,
    output logic       locked_out,
    output logic [3:0] fail_cnt
);

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_UNLOCKED = 3'd1,
        S_HOLD     = 3'd2,
        S_LOCKOUT  = 3'd3,
        S_ALARM    = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    // Count value at which the next bad entry triggers lockout.
    localparam logic [3:0]       FAIL_LIMIT   = 4'(MAX_FAILS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] timer_dec;
    logic [3:0]       fail_q, fail_d;
    logic             unlock_q, unlock_d;
    logic             alarm_q, alarm_d;
    logic             locked_out_q, locked_out_d;

    // Next-state, timer and fail-count logic; outputs decoded from next state
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        fail_d    = fail_q;
        timer_dec = (timer_q != '0) ? timer_q - CNT_W'(1) : '0;

        case (state_q)
            S_LOCKED: begin
                if (!door_closed) begin
                    state_d = S_ALARM;
                end else if (code_ok) begin
                    state_d = S_UNLOCKED;
                    timer_d = UNLOCK_LOAD;
                    fail_d  = '0;
                end else if (code_bad) begin
                    if (fail_q == FAIL_LIMIT) begin
                        state_d = S_LOCKOUT;
                        timer_d = LOCKOUT_LOAD;
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_q + 4'd1;
                    end
                end
            end
            S_UNLOCKED: begin
                if (code_ok) begin
                    timer_d = UNLOCK_LOAD;
                end else if (lock_req || timer_q == '0) begin
                    state_d = door_closed ? S_LOCKED : S_HOLD;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_HOLD: begin
                if (door_closed) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKOUT: begin
                fail_d = '0;
                if (!door_closed) begin
                    state_d = S_ALARM;
                end else if (timer_q == '0) begin
                    state_d = S_LOCKED;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_ALARM: begin
                if (code_ok) begin
                    state_d = S_UNLOCKED;
                    timer_d = UNLOCK_LOAD;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = S_LOCKED;
                timer_d = '0;
                fail_d  = '0;
            end
        endcase

        // Decoding from the next state keeps outputs registered yet aligned
        // with the state they describe.
        unlock_d     = (state_d == S_UNLOCKED) || (state_d == S_HOLD);
        alarm_d      = (state_d == S_ALARM);
        locked_out_d = (state_d == S_LOCKOUT);
    end

    // State, timer, fail count and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_LOCKED;
            timer_q      <= '0;
            fail_q       <= '0;
            unlock_q     <= 1'b0;
            alarm_q      <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fail_q       <= fail_d;
            unlock_q     <= unlock_d;
            alarm_q      <= alarm_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign unlock     = unlock_q;
    assign alarm      = alarm_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_q;

endmodule
